// File: rtl/ls299.sv
// ls299 -- 8-bit universal shift/storage register (SN74LS299 cycle model).
// Modes {S1,S0}: 00 hold, 01 shift right (SR -> QA), 10 shift left (SL -> QH),
// 11 parallel load. CKE qualifies the device clock on the system clock.
// CLR_N clears asynchronously; its release passes through a 2-stage
// synchronizer, so the register stays cleared for two more edges.
// Optional build macro: LS299_TRISTATE_EN replaces IO_I/IO_O/IO_OE with a
// single bidirectional IO bus (board-level simulation only).
module ls299 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             CKE,
  input  logic             S0,
  input  logic             S1,
  input  logic             G1_N,
  input  logic             G2_N,
  input  logic             SR,
  input  logic             SL,
`ifdef LS299_TRISTATE_EN
  inout  wire  [WIDTH-1:0] IO,
`else
  input  logic [WIDTH-1:0] IO_I,
  output logic [WIDTH-1:0] IO_O,
  output logic             IO_OE,
`endif
  output logic             QA_P,
  output logic             QH_P
);

  logic [1:0]       sync_q, sync_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] pin_in;
  logic             run;
  logic             oe;

  // Load mode always releases the pins so an external bus can drive them.
  assign oe = !G1_N && !G2_N && !(S1 && S0);

`ifdef LS299_TRISTATE_EN
  assign IO     = oe ? q_q : {WIDTH{1'bz}};
  assign pin_in = IO;
`else
  assign pin_in = IO_I;
  assign IO_O   = q_q;
  assign IO_OE  = oe;
`endif

  assign QA_P = q_q[0];
  assign QH_P = q_q[WIDTH-1];
  assign run  = sync_q[1];

  // Deassertion synchronizer: shifts ones in after CLR_N releases.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  // Synchronizer register; cleared at once when CLR_N asserts.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // Mode decode; nothing happens until the synchronizer has released.
  always_comb begin
    q_d = q_q;
    if (run && CKE) begin
      case ({S1, S0})
        2'b01:   q_d = {q_q[WIDTH-2:0], SR};
        2'b10:   q_d = {SL, q_q[WIDTH-1:1]};
        2'b11:   q_d = pin_in;
        default: q_d = q_q;
      endcase
    end
  end

  // Storage register with asynchronous clear.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: tb/tb_ls299.sv
// tb_ls299 -- table-driven check of ls299 with an expected-value queue.
module tb_ls299;

  logic       CLK = 1'b0;
  logic       CLR_N, CKE, S0, S1, G1_N, G2_N, SR, SL;
  logic [7:0] IO_I;
  logic [7:0] IO_O;
  logic       IO_OE, QA_P, QH_P;

  ls299 #(.WIDTH(8)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CKE(CKE), .S0(S0), .S1(S1),
    .G1_N(G1_N), .G2_N(G2_N), .SR(SR), .SL(SL),
    .IO_I(IO_I), .IO_O(IO_O), .IO_OE(IO_OE), .QA_P(QA_P), .QH_P(QH_P)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       cke;
    logic [1:0] s;
    logic       g1, g2, sr, sl;
    logic [7:0] io;
    logic [7:0] eq;
    logic       eoe;
  } vec_t;

  typedef struct {
    int         tag;
    logic [7:0] q;
    logic       oe;
  } exp_t;

  vec_t tbl[17];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic cke, logic [1:0] s, logic g1, logic g2,
                              logic sr, logic sl, logic [7:0] io,
                              logic [7:0] eq, logic eoe);
    vec_t v;
    v.cke = cke; v.s = s; v.g1 = g1; v.g2 = g2; v.sr = sr; v.sl = sl;
    v.io = io; v.eq = eq; v.eoe = eoe;
    return v;
  endfunction

  task automatic cmp(input string nm, input int tag, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s tag=%0d got=%h want=%h", nm, tag, act, exp);
    end
  endtask

  task automatic push(input int tag, input logic [7:0] q, input logic oe);
    exp_t e;
    e.tag = tag; e.q = q; e.oe = oe;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty got=0 want=1");
      return;
    end
    e = sb.pop_front();
    cmp("io_o",  e.tag, IO_O,          e.q);
    cmp("qa_p",  e.tag, {7'd0, QA_P},  {7'd0, e.q[0]});
    cmp("qh_p",  e.tag, {7'd0, QH_P},  {7'd0, e.q[7]});
    cmp("io_oe", e.tag, {7'd0, IO_OE}, {7'd0, e.oe});
  endtask

  task automatic drive(input logic cke, input logic [1:0] s, input logic g1,
                       input logic g2, input logic sr, input logic sl,
                       input logic [7:0] io);
    CKE = cke; S1 = s[1]; S0 = s[0]; G1_N = g1; G2_N = g2;
    SR = sr; SL = sl; IO_I = io;
  endtask

  initial begin
    logic [7:0] m;
    // Table: starting state 8'hFF after the reset sequence below.
    tbl[0]  = mk(1, 2'b11, 0, 0, 0, 0, 8'hA5, 8'hA5, 0);
    tbl[1]  = mk(1, 2'b01, 0, 0, 1, 0, 8'h00, 8'h4B, 1);
    tbl[2]  = mk(1, 2'b01, 0, 0, 1, 0, 8'h00, 8'h97, 1);
    tbl[3]  = mk(1, 2'b01, 0, 0, 1, 0, 8'h00, 8'h2F, 1);
    tbl[4]  = mk(1, 2'b01, 0, 0, 1, 0, 8'h00, 8'h5F, 1);
    tbl[5]  = mk(1, 2'b11, 0, 0, 0, 0, 8'h81, 8'h81, 0);
    tbl[6]  = mk(1, 2'b10, 0, 0, 0, 0, 8'h00, 8'h40, 1);
    tbl[7]  = mk(0, 2'b10, 0, 0, 0, 0, 8'h00, 8'h40, 1);
    tbl[8]  = mk(1, 2'b10, 0, 0, 0, 0, 8'h00, 8'h20, 1);
    tbl[9]  = mk(1, 2'b11, 0, 0, 0, 0, 8'h3C, 8'h3C, 0);
    tbl[10] = mk(1, 2'b00, 0, 0, 0, 0, 8'hFF, 8'h3C, 1);
    tbl[11] = mk(1, 2'b00, 0, 1, 0, 0, 8'hFF, 8'h3C, 0);
    tbl[12] = mk(1, 2'b00, 1, 0, 0, 0, 8'hFF, 8'h3C, 0);
    tbl[13] = mk(1, 2'b11, 0, 0, 0, 0, 8'h3C, 8'h3C, 0);
    tbl[14] = mk(1, 2'b10, 0, 0, 0, 1, 8'h00, 8'h9E, 1);
    tbl[15] = mk(1, 2'b01, 0, 0, 0, 0, 8'h00, 8'h3C, 1);
    tbl[16] = mk(0, 2'b11, 0, 0, 1, 1, 8'h00, 8'h3C, 0);

    // Reset held with load mode and all-ones bus: register must stay clear.
    CLR_N = 1'b0;
    drive(1, 2'b11, 0, 0, 0, 0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); push(100 + i, 8'h00, 0);
      @(posedge CLK); #1; check();
    end
    // Release: two synchronizer edges are ignored, the third loads.
    @(negedge CLK); CLR_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      push(110 + i, (i == 2) ? 8'hFF : 8'h00, 0);
      @(posedge CLK); #1; check();
    end

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      drive(tbl[i].cke, tbl[i].s, tbl[i].g1, tbl[i].g2, tbl[i].sr,
            tbl[i].sl, tbl[i].io);
      push(i, tbl[i].eq, tbl[i].eoe);
      @(posedge CLK); #1; check();
    end

    // Asynchronous clear in the middle of a shift run.
    @(negedge CLK); drive(1, 2'b01, 0, 0, 1, 0, 8'h00);
    push(200, 8'h79, 1);
    @(posedge CLK); #1; check();
    @(negedge CLK); #2; CLR_N = 1'b0; #1;
    push(201, 8'h00, 1); check();
    @(posedge CLK); #1; push(202, 8'h00, 1); check();
    @(negedge CLK); CLR_N = 1'b1; drive(1, 2'b11, 0, 0, 0, 0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      push(210 + i, (i == 2) ? 8'h01 : 8'h00, 0);
      @(posedge CLK); #1; check();
    end

    // Circular shift right with QH' looped back to SR.
    m = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(1, 2'b01, 0, 0, QH_P, 0, 8'h00);
      m = {m[6:0], m[7]};
      push(300 + i, m, 1);
      @(posedge CLK); #1; check();
    end
    cmp("circular_final", 399, IO_O, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
